// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and baud-divider rounding for the UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } uart_state_e;

  // Nearest-integer clocks per oversample tick.
  function automatic int calc_div(input longint clk_hz, input longint baud, input longint ovs);
    longint den;
    den = baud * ovs;
    return int'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled 2-of-3 majority bit decisions,
// optional parity, 1-2 stop bits, break wait and a single-word holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int SW  = $clog2(OVS);
  localparam logic [SW-1:0] S_LO  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVS / 2 + 1);

  if (OVS != 8 && OVS != 16) begin : g_bad_ovs
    $error("uart_rx_cfg: OVS must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_rx_cfg: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_cfg: CLK_HZ too low for BAUD*OVS");
  end

  uart_state_e          state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [1:0]           maj_q, maj_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, tick_clr, decide, bit_val, done, par_exp, rx_s, rx_prev;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detect.
  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];
  assign bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
  assign decide  = tick && (samp_q == S_HI);
  assign par_exp = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], rx};
    samp_d       = samp_q;
    maj_d        = maj_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shift_d      = shift_q;
    ferr_d       = ferr_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    tick_clr     = 1'b0;
    done         = 1'b0;

    if (tick) begin
      samp_d = samp_q + 1'b1;
      if (samp_q == S_LO)  maj_d[1] = rx_s;
      if (samp_q == S_MID) maj_d[0] = rx_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d    = ST_START;
          tick_clr   = 1'b1;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          ferr_d     = 1'b0;
          perr_d     = 1'b0;
        end
      end
      ST_START: begin
        if (decide) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (decide) begin
          perr_d  = (bit_val != par_exp);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (!bit_val) ferr_d = 1'b1;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = (ferr_q || !bit_val) ? ST_BRK_WAIT : ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      ST_BRK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick_clr) samp_d = '0;

    // Holding register: a completing frame may replace the word only if it is being taken now.
    if (done) begin
      if (!valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        frame_err_d  = ferr_q | ~bit_val;
        parity_err_d = perr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sync_q       <= 3'b111;
      samp_q       <= '0;
      maj_q        <= 2'b11;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      samp_q       <= samp_d;
      maj_q        <= maj_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance (DIV=4, OVS=16) and a
// 7E2 instance (DIV=4, OVS=8) driven by directed frames.
module tb_uart_rx_cfg;

  localparam int B8 = 64;  // clocks per bit, 8N1 instance
  localparam int B7 = 32;  // clocks per bit, 7E2 instance

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx8 = 1'b1, rx7 = 1'b1;
  logic       rdy8 = 1'b1, rdy7 = 1'b1;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       v8, fe8, pe8, ov8, bz8;
  logic       v7, fe7, pe7, ov7, bz7;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_HZ(6_400_000), .BAUD(100_000), .OVS(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
    .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .busy(bz8));

  uart_rx_cfg #(.CLK_HZ(3_300_000), .BAUD(100_000), .OVS(8), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
    .frame_err(fe7), .parity_err(pe7), .overrun(ov7), .busy(bz7));

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  int   n_cmp = 0, n_bad = 0;
  int   ovr8 = 0, ovr7 = 0;
  logic acc8_prev = 1'b0, acc7_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 8) rx8 = v; else rx7 = v;
    repeat (n) @(posedge clk);
  endtask

  // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send(input int sel, input logic [7:0] d, input int nb, input int par,
                      input logic stop, input int nstop);
    int bt;
    bt = (sel == 8) ? B8 : B7;
    drive(sel, 1'b0, bt);
    for (int i = 0; i < nb; i++) drive(sel, d[i], bt);
    if (par >= 0) drive(sel, par[0], bt);
    for (int i = 0; i < nstop; i++) drive(sel, stop, bt);
  endtask

  task automatic exp8(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    q8.push_back(e);
  endtask

  task automatic exp7(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    q7.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    exp_t e;
    if (ov8) ovr8++;
    if (ov7) ovr7++;
    if (acc8_prev) check("dut8 valid drops after accept", {31'd0, v8}, 32'd0);
    if (acc7_prev) check("dut7 valid drops after accept", {31'd0, v7}, 32'd0);
    acc8_prev = v8 && rdy8;
    acc7_prev = v7 && rdy7;
    if (v8 && rdy8) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut8 unexpected word: got 0x%0h, want none", d8);
      end else begin
        e = q8.pop_front();
        check("dut8 rx_data", {24'd0, d8}, {24'd0, e.d});
        check("dut8 frame_err", {31'd0, fe8}, {31'd0, e.fe});
        check("dut8 parity_err", {31'd0, pe8}, {31'd0, e.pe});
      end
    end
    if (v7 && rdy7) begin
      if (q7.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut7 unexpected word: got 0x%0h, want none", d7);
      end else begin
        e = q7.pop_front();
        check("dut7 rx_data", {25'd0, d7}, {24'd0, e.d});
        check("dut7 frame_err", {31'd0, fe7}, {31'd0, e.fe});
        check("dut7 parity_err", {31'd0, pe7}, {31'd0, e.pe});
      end
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset rx_valid", {30'd0, v8, v7}, 32'd0);
    check("reset rx_data", {17'd0, d7, d8}, 32'd0);
    check("reset flags", {26'd0, fe8, pe8, ov8, fe7, pe7, ov7}, 32'd0);
    check("reset busy", {30'd0, bz8, bz7}, 32'd0);
    @(posedge clk);
    rst = 1'b1;
    repeat (2 * B8) @(posedge clk);

    // 8N1 basic word
    exp8(8'h31, 1'b0, 1'b0);
    send(8, 8'h31, 8, -1, 1'b1, 1);
    repeat (2 * B8) @(posedge clk);

    // 7E2: 0x41 has even ones, so expected parity is 0
    exp7(8'h41, 1'b0, 1'b1);
    send(7, 8'h41, 7, 1, 1'b1, 2);
    repeat (2 * B7) @(posedge clk);
    exp7(8'h41, 1'b0, 1'b0);
    send(7, 8'h41, 7, 0, 1'b1, 2);
    repeat (2 * B7) @(posedge clk);

    // Break: zero stop bit then line held low
    exp8(8'h00, 1'b1, 1'b0);
    send(8, 8'h00, 8, -1, 1'b0, 1);
    drive(8, 1'b0, 3 * B8);
    @(negedge clk);
    check("break busy while low", {31'd0, bz8}, 32'd1);
    drive(8, 1'b1, 2 * B8);
    @(negedge clk);
    check("break busy after high", {31'd0, bz8}, 32'd0);
    exp8(8'hA5, 1'b0, 1'b0);
    send(8, 8'hA5, 8, -1, 1'b1, 1);
    repeat (2 * B8) @(posedge clk);

    // False start glitch of ~1/5 bit
    drive(8, 1'b0, B8 / 5);
    @(negedge clk);
    check("glitch busy", {31'd0, bz8}, 32'd1);
    rx8 = 1'b1;
    for (int i = 0; i < B8; i++) begin
      @(negedge clk);
      if (!bz8) break;
    end
    check("glitch busy cleared", {31'd0, bz8}, 32'd0);
    repeat (2 * B8) @(posedge clk);

    // Overrun: consumer stalled across two frames
    @(posedge clk); #1;
    rdy8 = 1'b0;
    exp8(8'h55, 1'b0, 1'b0);
    send(8, 8'h55, 8, -1, 1'b1, 1);
    repeat (B8) @(posedge clk);
    send(8, 8'hAA, 8, -1, 1'b1, 1);
    repeat (B8) @(posedge clk);
    @(negedge clk);
    check("overrun pulses", ovr8, 32'd1);
    check("held word kept", {24'd0, d8}, 32'h55);
    check("held valid", {31'd0, v8}, 32'd1);
    @(posedge clk); #1;
    rdy8 = 1'b1;
    repeat (2) @(negedge clk);
    check("valid after accept", {31'd0, v8}, 32'd0);
    repeat (2 * B8) @(posedge clk);

    // Reset in the middle of data bit 3 of 0xF0
    drive(8, 1'b0, B8);
    for (int i = 0; i < 3; i++) drive(8, 1'b0, B8);
    drive(8, 1'b0, B8 / 2);
    rst = 1'b0;
    rx8 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid-frame reset busy", {31'd0, bz8}, 32'd0);
    check("mid-frame reset valid", {31'd0, v8}, 32'd0);
    @(posedge clk);
    rst = 1'b1;
    repeat (2 * B8) @(posedge clk);
    exp8(8'h7E, 1'b0, 1'b0);
    send(8, 8'h7E, 8, -1, 1'b1, 1);
    repeat (2 * B8) @(posedge clk);

    for (int i = 0; i < 1000; i++) begin
      if (q8.size() == 0 && q7.size() == 0) break;
      @(posedge clk);
    end
    check("dut8 words outstanding", q8.size(), 32'd0);
    check("dut7 words outstanding", q7.size(), 32'd0);
    check("dut8 overrun total", ovr8, 32'd1);
    check("dut7 overrun total", ovr7, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
